// File: rtl/op_unit_arbiter_pkg.sv
// Shared definitions for the op-unit arbiter: FSM state encoding and default sizing.
package opu_arb_pkg;

    localparam int unsigned DEF_WIDTH  = 4;
    localparam int unsigned DEF_OP_LAT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/op_unit_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic win_valid,
    output logic win_idx
);

    always_comb begin
        win_valid = req0 | req1;
        win_idx   = (req0 && req1) ? ~last_served : req1;
    end

endmodule

// File: rtl/op_unit_arbiter.sv
// Shares one two-operand op unit between two requesters: round-robin grant,
// operand latch, fixed-latency wait, result capture with a done pulse.
module op_unit_arbiter
    import opu_arb_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned OP_LAT = DEF_OP_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             mode0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             mode1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] dp_in1,
    output logic [WIDTH-1:0] dp_in2,
    output logic             dp_in0,
    input  logic [WIDTH-1:0] dp_out
);

    state_t     state, state_nxt;
    logic       owner;
    logic       last_served;
    logic [3:0] cnt;
    logic       win_valid, win_idx;
    logic       grant, capture;
    logic       gnt0_d, gnt1_d, done0_d, done1_d, busy_d;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_served),
        .win_valid   (win_valid),
        .win_idx     (win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded one cycle early and registered below, so every
    // port comes straight from a flop.
    always_comb begin
        grant   = (state == IDLE) && win_valid;
        capture = (state == WAIT) && (cnt == '0);
        gnt0_d  = grant && !win_idx;
        gnt1_d  = grant && win_idx;
        done0_d = capture && !owner;
        done1_d = capture && owner;
        busy_d  = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            busy        <= 1'b0;
            result      <= '0;
            dp_in1      <= '0;
            dp_in2      <= '0;
            dp_in0      <= 1'b0;
            owner       <= 1'b0;
            last_served <= 1'b1;
            cnt         <= '0;
        end else begin
            gnt0  <= gnt0_d;
            gnt1  <= gnt1_d;
            done0 <= done0_d;
            done1 <= done1_d;
            busy  <= busy_d;
            if (grant) begin
                owner  <= win_idx;
                dp_in1 <= win_idx ? a1 : a0;
                dp_in2 <= win_idx ? b1 : b0;
                dp_in0 <= win_idx ? mode1 : mode0;
            end
            if (state == ISSUE) cnt <= 4'(OP_LAT - 1);
            if (state == WAIT && cnt != '0) cnt <= cnt - 4'd1;
            if (capture) begin
                result      <= dp_out;
                last_served <= owner;
                dp_in0      <= 1'b0;
            end
        end
    end

endmodule
